// File: rtl/hsv_core_pkg.sv
// Shared definitions for the control/status execution unit: CSR map, trap causes,
// FSM states and the decoded system-instruction fields.
package hsv_core_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [31:0] MCAUSE_ILLEGAL_INSN = 32'd2;
    localparam logic [31:0] MCAUSE_BREAKPOINT   = 32'd3;
    localparam logic [31:0] MCAUSE_ECALL_M      = 32'd11;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_IRQ = 1'b1
    } ctrlstatus_state_t;

    typedef struct packed {
        logic       syscall;
        logic       breakpoint;
        logic       mode_return;
        logic       wait_irq;
        logic       read;
        logic       write;
        logic       write_mask;
        logic       write_flip;
        logic       is_immediate;
        logic [4:0] short_immediate;
    } ctrlstatus_data_t;

    // write_mask selects set/clear semantics; without it the source replaces the CSR.
    function automatic logic [31:0] csr_modify(input logic [31:0] old_value,
                                               input logic [31:0] src,
                                               input logic        write_mask,
                                               input logic        write_flip);
        if (!write_mask) begin
            return src;
        end
        if (write_flip) begin
            return old_value & ~src;
        end
        return old_value | src;
    endfunction

endpackage

// File: rtl/hsv_core_ctrlstatus_regfile.sv
// Machine-mode CSR storage with address decode, read mux and access legality.
// Trap entry and mret update mstatus/mepc/mcause directly, taking priority over writes.
module hsv_core_ctrlstatus_regfile
    import hsv_core_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq_timer,
    input  logic [11:0] csr_addr,
    input  logic        write_intent,
    input  logic        write_en,
    input  logic [31:0] write_data,
    input  logic        trap_en,
    input  logic [31:0] trap_cause,
    input  logic [29:0] trap_pc_base,
    input  logic        mret_en,
    output logic [31:0] read_data,
    output logic        legal,
    output logic [29:0] mtvec_base,
    output logic [29:0] mepc_base,
    output logic        irq_pending
);

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_mtie;
    logic        mip_mtip;
    logic [31:0] mscratch;
    logic [31:0] mcause;
    logic        implemented;

    always_comb begin
        read_data   = 32'd0;
        implemented = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:  read_data = {24'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
            CSR_MIE:      read_data = {24'd0, mie_mtie, 7'd0};
            CSR_MIP:      read_data = {24'd0, mip_mtip, 7'd0};
            CSR_MTVEC:    read_data = {mtvec_base, 2'b00};
            CSR_MSCRATCH: read_data = mscratch;
            CSR_MEPC:     read_data = {mepc_base, 2'b00};
            CSR_MCAUSE:   read_data = mcause;
            CSR_MHARTID:  read_data = HART_ID;
            default:      implemented = 1'b0;
        endcase
    end

    // The top address bits 2'b11 mark the read-only CSR space.
    assign legal       = implemented & ~(write_intent & (csr_addr[11:10] == 2'b11));
    assign irq_pending = mip_mtip & mie_mtie;

    always_ff @(posedge clk) begin
        mip_mtip <= irq_timer;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mtvec_base   <= MTVEC_RESET[31:2];
            mscratch     <= 32'd0;
            mepc_base    <= 30'd0;
            mcause       <= 32'd0;
        end else if (trap_en) begin
            mepc_base    <= trap_pc_base;
            mcause       <= trap_cause;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret_en) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (write_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie  <= write_data[3];
                    mstatus_mpie <= write_data[7];
                end
                CSR_MIE:      mie_mtie   <= write_data[7];
                CSR_MTVEC:    mtvec_base <= write_data[31:2];
                CSR_MSCRATCH: mscratch   <= write_data;
                CSR_MEPC:     mepc_base  <= write_data[31:2];
                CSR_MCAUSE:   mcause     <= write_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hsv_core_ctrlstatus_exec.sv
// Executes CSR accesses, ecall/ebreak/mret and wfi with a single registered result slot.
// A wfi parks the unit in WAIT_IRQ; its result is released once an enabled interrupt is pending.
module hsv_core_ctrlstatus_exec
    import hsv_core_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic             clk_core,
    input  logic             rst_core,
    input  logic             in_valid,
    output logic             in_ready,
    input  ctrlstatus_data_t in_data,
    input  logic [11:0]      in_csr_addr,
    input  logic [4:0]       in_rd_addr,
    input  logic [31:0]      in_rs1_value,
    input  logic [31:0]      in_pc,
    input  logic             irq_timer,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd_addr,
    output logic [31:0]      out_rd_value,
    output logic             out_writeback,
    output logic             out_redirect,
    output logic [31:0]      out_next_pc,
    output logic             out_trap
);

    ctrlstatus_state_t state;

    logic        accept;
    logic        is_csr_op;
    logic        csr_legal;
    logic        illegal;
    logic        take_trap;
    logic        do_mret;
    logic        do_wfi;
    logic        csr_write_en;
    logic [31:0] csr_src;
    logic [31:0] csr_old;
    logic [31:0] csr_new;
    logic [31:0] trap_cause;
    logic [29:0] mtvec_base;
    logic [29:0] mepc_base;
    logic        irq_pending;

    assign in_ready = (state == IDLE) & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    // System ops are prioritised ecall > ebreak > mret > wfi; anything else is a CSR access.
    assign is_csr_op = ~(in_data.syscall | in_data.breakpoint | in_data.mode_return | in_data.wait_irq);
    assign illegal   = is_csr_op & (~csr_legal | (~in_data.read & ~in_data.write));
    assign take_trap = in_data.syscall | in_data.breakpoint | illegal;
    assign do_mret   = in_data.mode_return & ~in_data.syscall & ~in_data.breakpoint;
    assign do_wfi    = in_data.wait_irq & ~in_data.mode_return & ~in_data.syscall & ~in_data.breakpoint;

    assign trap_cause = in_data.syscall    ? MCAUSE_ECALL_M :
                        in_data.breakpoint ? MCAUSE_BREAKPOINT : MCAUSE_ILLEGAL_INSN;

    assign csr_src      = in_data.is_immediate ? {27'd0, in_data.short_immediate} : in_rs1_value;
    assign csr_new      = csr_modify(csr_old, csr_src, in_data.write_mask, in_data.write_flip);
    assign csr_write_en = accept & is_csr_op & ~illegal & in_data.write;

    hsv_core_ctrlstatus_regfile #(
        .HART_ID     (HART_ID),
        .MTVEC_RESET (MTVEC_RESET)
    ) u_regfile (
        .clk          (clk_core),
        .rst          (rst_core),
        .irq_timer    (irq_timer),
        .csr_addr     (in_csr_addr),
        .write_intent (in_data.write),
        .write_en     (csr_write_en),
        .write_data   (csr_new),
        .trap_en      (accept & take_trap),
        .trap_cause   (trap_cause),
        .trap_pc_base (in_pc[31:2]),
        .mret_en      (accept & do_mret),
        .read_data    (csr_old),
        .legal        (csr_legal),
        .mtvec_base   (mtvec_base),
        .mepc_base    (mepc_base),
        .irq_pending  (irq_pending)
    );

    // A wfi loads its result fields at accept but only raises out_valid on wake.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state         <= IDLE;
            out_valid     <= 1'b0;
            out_trap      <= 1'b0;
            out_redirect  <= 1'b0;
            out_writeback <= 1'b0;
            out_rd_addr   <= 5'd0;
            out_rd_value  <= 32'd0;
            out_next_pc   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_rd_addr   <= in_rd_addr;
                        out_rd_value  <= (is_csr_op && !illegal) ? csr_old : 32'd0;
                        out_writeback <= is_csr_op & ~illegal & in_data.read;
                        out_trap      <= take_trap;
                        out_redirect  <= take_trap | do_mret;
                        if (take_trap) begin
                            out_next_pc <= {mtvec_base, 2'b00};
                        end else if (do_mret) begin
                            out_next_pc <= {mepc_base, 2'b00};
                        end else begin
                            out_next_pc <= in_pc + 32'd4;
                        end
                        out_valid <= ~do_wfi;
                        if (do_wfi) begin
                            state <= WAIT_IRQ;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                WAIT_IRQ: begin
                    if (irq_pending) begin
                        state     <= IDLE;
                        out_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hsv_core_ctrlstatus_exec.sv
// Randomised and directed bench for hsv_core_ctrlstatus_exec against a behavioural CSR model.
module tb_hsv_core_ctrlstatus_exec;
    import hsv_core_pkg::*;

    logic             clk_core = 1'b0;
    logic             rst_core;
    logic             in_valid;
    logic             in_ready;
    ctrlstatus_data_t in_data;
    logic [11:0]      in_csr_addr;
    logic [4:0]       in_rd_addr;
    logic [31:0]      in_rs1_value;
    logic [31:0]      in_pc;
    logic             irq_timer;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_rd_addr;
    logic [31:0]      out_rd_value;
    logic             out_writeback;
    logic             out_redirect;
    logic [31:0]      out_next_pc;
    logic             out_trap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_core = ~clk_core;

    hsv_core_ctrlstatus_exec #(
        .HART_ID     (32'h5),
        .MTVEC_RESET (32'h0000_1003)
    ) dut (
        .clk_core      (clk_core),
        .rst_core      (rst_core),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_csr_addr   (in_csr_addr),
        .in_rd_addr    (in_rd_addr),
        .in_rs1_value  (in_rs1_value),
        .in_pc         (in_pc),
        .irq_timer     (irq_timer),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rd_addr   (out_rd_addr),
        .out_rd_value  (out_rd_value),
        .out_writeback (out_writeback),
        .out_redirect  (out_redirect),
        .out_next_pc   (out_next_pc),
        .out_trap      (out_trap)
    );

    // Behavioural model: architectural CSR values plus the expected result slot.
    logic [31:0] m_mstatus = '0, m_mie = '0, m_mtvec = '0, m_mscratch = '0, m_mepc = '0, m_mcause = '0;
    logic        m_mtip = 1'b0, m_waiting = 1'b0;
    logic        e_valid = 1'b0, e_wb = 1'b0, e_redirect = 1'b0, e_trap = 1'b0, e_has_value = 1'b0;
    logic [4:0]  e_rd_addr = '0;
    logic [31:0] e_rd_value = '0, e_next_pc = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic model_read(input logic [11:0] addr, output logic [31:0] value);
        value = 32'd0;
        case (addr)
            12'h300: value = m_mstatus;
            12'h304: value = m_mie;
            12'h344: value = m_mtip ? 32'h80 : 32'h0;
            12'h305: value = m_mtvec;
            12'h340: value = m_mscratch;
            12'h341: value = m_mepc;
            12'h342: value = m_mcause;
            12'hF14: value = 32'h5;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic model_trap(input logic [31:0] cause);
        m_mepc     = in_pc & 32'hFFFF_FFFC;
        m_mcause   = cause;
        m_mstatus  = m_mstatus[3] ? 32'h80 : 32'h0;
        e_trap     = 1'b1;
        e_redirect = 1'b1;
        e_next_pc  = m_mtvec;
    endtask

    task automatic model_execute();
        logic [31:0] old_value, src, new_value;
        logic        exists, bad;
        e_rd_addr = in_rd_addr; e_wb = 0; e_trap = 0; e_redirect = 0;
        e_has_value = 0; e_rd_value = 0; e_next_pc = in_pc + 32'd4; e_valid = 1;
        if (in_data.syscall)         model_trap(32'd11);
        else if (in_data.breakpoint) model_trap(32'd3);
        else if (in_data.mode_return) begin
            m_mstatus  = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            e_redirect = 1;
            e_next_pc  = m_mepc;
        end else if (in_data.wait_irq) begin
            m_waiting = 1;
            e_valid   = 0;
        end else begin
            exists = model_read(in_csr_addr, old_value);
            bad = !exists || (in_data.write && in_csr_addr[11:10] == 2'b11) || (!in_data.read && !in_data.write);
            if (bad) model_trap(32'd2);
            else begin
                src = in_data.is_immediate ? {27'd0, in_data.short_immediate} : in_rs1_value;
                if (!in_data.write_mask)     new_value = src;
                else if (in_data.write_flip) new_value = old_value & ~src;
                else                         new_value = old_value | src;
                if (in_data.write) begin
                    case (in_csr_addr)
                        12'h300: m_mstatus  = new_value & 32'h88;
                        12'h304: m_mie      = new_value & 32'h80;
                        12'h305: m_mtvec    = new_value & 32'hFFFF_FFFC;
                        12'h340: m_mscratch = new_value;
                        12'h341: m_mepc     = new_value & 32'hFFFF_FFFC;
                        12'h342: m_mcause   = new_value;
                        default: ;
                    endcase
                end
                e_rd_value  = old_value;
                e_has_value = 1;
                e_wb        = in_data.read;
            end
        end
    endtask

    always @(posedge clk_core) begin
        if (rst_core) begin
            m_mstatus = 0; m_mie = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtvec = 32'h1000;
            m_waiting = 0; e_valid = 0;
        end else if (m_waiting) begin
            if (m_mtip && m_mie[7]) begin
                m_waiting = 0;
                e_valid   = 1;
            end
        end else if (in_valid && (!e_valid || out_ready)) begin
            model_execute();
        end else if (out_ready) begin
            e_valid = 0;
        end
        m_mtip = irq_timer;
    end

    // Single compare process: every non-reset cycle, away from the active edge.
    always @(negedge clk_core) begin
        if (!rst_core) begin
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, !m_waiting && (!e_valid || out_ready)});
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
            if (e_valid) begin
                checkOutput("out_trap", {31'd0, out_trap}, {31'd0, e_trap});
                checkOutput("out_redirect", {31'd0, out_redirect}, {31'd0, e_redirect});
                checkOutput("out_writeback", {31'd0, out_writeback}, {31'd0, e_wb});
                checkOutput("out_next_pc", out_next_pc, e_next_pc);
                if (!e_trap) checkOutput("out_rd_addr", {27'd0, out_rd_addr}, {27'd0, e_rd_addr});
                if (e_has_value) checkOutput("out_rd_value", out_rd_value, e_rd_value);
            end
        end
    end

    function automatic ctrlstatus_data_t csr_op(input logic rd, input logic wr, input logic mask,
                                                input logic flip, input logic imm, input logic [4:0] immv);
        ctrlstatus_data_t d = '0;
        d.read = rd; d.write = wr; d.write_mask = mask; d.write_flip = flip;
        d.is_immediate = imm; d.short_immediate = immv;
        return d;
    endfunction

    function automatic ctrlstatus_data_t sys_op(input int kind);
        ctrlstatus_data_t d = '0;
        d.syscall = (kind == 0); d.breakpoint = (kind == 1);
        d.mode_return = (kind == 2); d.wait_irq = (kind == 3);
        return d;
    endfunction

    // Present one instruction and hold it until the DUT accepts it (bounded).
    task automatic applyStimulus(input ctrlstatus_data_t d, input logic [11:0] addr,
                                 input logic [31:0] rs1, input logic [31:0] pc, input logic [4:0] rd);
        int waited = 0;
        in_data = d; in_csr_addr = addr; in_rs1_value = rs1; in_pc = pc; in_rd_addr = rd;
        in_valid = 1'b1;
        @(negedge clk_core);
        while (!in_ready && waited < 50) begin
            @(negedge clk_core);
            waited++;
        end
        if (!in_ready) checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk_core);
        #2 in_valid = 1'b0;
    endtask

    task automatic expectRead(input string name, input logic [11:0] addr, input logic [31:0] expected);
        applyStimulus(csr_op(1, 0, 1, 0, 0, 0), addr, 32'd0, 32'h80, 5'd1);
        @(negedge clk_core);
        checkOutput(name, out_rd_value, expected);
        @(posedge clk_core); #2;
    endtask

    task automatic expectResult(input string name, input logic [31:0] value, input logic wb,
                                input logic trap, input logic redirect, input logic [31:0] npc);
        @(negedge clk_core);
        checkOutput({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({name, "_value"}, out_rd_value, value);
        checkOutput({name, "_wb"}, {31'd0, out_writeback}, {31'd0, wb});
        checkOutput({name, "_trap"}, {31'd0, out_trap}, {31'd0, trap});
        checkOutput({name, "_redirect"}, {31'd0, out_redirect}, {31'd0, redirect});
        checkOutput({name, "_next_pc"}, out_next_pc, npc);
        @(posedge clk_core); #2;
    endtask

    logic [11:0] addr_list [11] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'h344, 12'hF14, 12'h7C0, 12'hC00, 12'h301};

    initial begin
        int waited;
        logic [31:0] rnd;
        ctrlstatus_data_t d;
        rst_core = 1; in_valid = 0; in_data = '0; in_csr_addr = 0; in_rd_addr = 0;
        in_rs1_value = 0; in_pc = 0; out_ready = 1; irq_timer = 0;
        repeat (3) @(posedge clk_core);
        #2 rst_core = 0;
        @(negedge clk_core);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_next_pc", out_next_pc, 32'd0);
        checkOutput("reset_rd_value", out_rd_value, 32'd0);
        @(posedge clk_core); #2;

        expectRead("mtvec_reset", CSR_MTVEC, 32'h1000);
        expectRead("mhartid", CSR_MHARTID, 32'h5);

        applyStimulus(csr_op(1, 1, 0, 0, 0, 0), CSR_MSCRATCH, 32'hDEADBEEF, 32'h40, 5'd5);
        @(negedge clk_core);
        checkOutput("csrrw_rd_addr", {27'd0, out_rd_addr}, 32'd5);
        checkOutput("csrrw_value", out_rd_value, 32'd0);
        checkOutput("csrrw_wb", {31'd0, out_writeback}, 32'd1);
        @(posedge clk_core); #2;
        expectRead("mscratch_readback", CSR_MSCRATCH, 32'hDEADBEEF);

        applyStimulus(csr_op(1, 1, 0, 0, 0, 0), CSR_MTVEC, 32'h200, 32'h50, 5'd2);
        expectResult("mtvec_write", 32'h1000, 1, 0, 0, 32'h54);
        applyStimulus(csr_op(1, 1, 1, 0, 1, 5'd8), CSR_MSTATUS, 32'd0, 32'h60, 5'd3);
        expectResult("csrrsi_mie", 32'h0, 1, 0, 0, 32'h64);
        applyStimulus(csr_op(1, 1, 1, 1, 1, 5'd8), CSR_MSTATUS, 32'd0, 32'h68, 5'd3);
        expectResult("csrrci_mie", 32'h8, 1, 0, 0, 32'h6C);
        expectRead("mstatus_cleared", CSR_MSTATUS, 32'h0);

        applyStimulus(csr_op(1, 1, 1, 0, 1, 5'd8), CSR_MSTATUS, 32'd0, 32'h70, 5'd0);
        @(negedge clk_core); @(posedge clk_core); #2;
        applyStimulus(sys_op(0), 12'h000, 32'd0, 32'h100, 5'd0);
        expectResult("ecall", 32'h0, 0, 1, 1, 32'h200);
        expectRead("ecall_mepc", CSR_MEPC, 32'h100);
        expectRead("ecall_mcause", CSR_MCAUSE, 32'd11);
        expectRead("ecall_mstatus", CSR_MSTATUS, 32'h80);

        applyStimulus(csr_op(1, 1, 0, 0, 0, 0), CSR_MEPC, 32'h104, 32'h200, 5'd4);
        expectResult("mepc_write", 32'h100, 1, 0, 0, 32'h204);
        applyStimulus(sys_op(2), 12'h302, 32'd0, 32'h208, 5'd0);
        expectResult("mret", 32'h0, 0, 0, 1, 32'h104);
        expectRead("mret_mstatus", CSR_MSTATUS, 32'h88);

        applyStimulus(csr_op(0, 1, 0, 0, 0, 0), CSR_MIE, 32'h80, 32'h300, 5'd0);
        @(negedge clk_core); @(posedge clk_core); #2;
        applyStimulus(sys_op(3), 12'h105, 32'd0, 32'h400, 5'd0);
        repeat (3) begin
            @(negedge clk_core);
            checkOutput("wfi_blocked_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("wfi_no_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk_core); #2;
        out_ready = 0; irq_timer = 1;
        waited = 0;
        @(negedge clk_core);
        while (!out_valid && waited < 10) begin
            @(negedge clk_core);
            waited++;
        end
        checkOutput("wfi_wake_valid", {31'd0, out_valid}, 32'd1);
        repeat (3) begin
            @(negedge clk_core);
            checkOutput("wfi_stall_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("wfi_stall_next_pc", out_next_pc, 32'h404);
            checkOutput("wfi_stall_redirect", {31'd0, out_redirect}, 32'd0);
        end
        @(posedge clk_core); #2;
        out_ready = 1; irq_timer = 0;
        @(negedge clk_core); @(posedge clk_core); #2;

        applyStimulus(csr_op(1, 1, 0, 0, 0, 0), CSR_MHARTID, 32'h55, 32'h500, 5'd7);
        expectResult("mhartid_write", 32'h0, 0, 1, 1, 32'h200);
        expectRead("illegal_mcause", CSR_MCAUSE, 32'd2);
        expectRead("mhartid_kept", CSR_MHARTID, 32'h5);
        applyStimulus(csr_op(1, 1, 0, 0, 0, 0), 12'h7C0, 32'h55, 32'h600, 5'd7);
        expectResult("unimpl_write", 32'h0, 0, 1, 1, 32'h200);

        // Random traffic with back-pressure, timer toggles and occasional mid-flight resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_core  = ($urandom_range(0, 399) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) irq_timer = ~irq_timer;
            in_valid = ($urandom_range(0, 9) < 7);
            waited = $urandom_range(0, 19);
            if (waited < 14 || (waited >= 18 && !m_mie[7])) begin
                d = csr_op($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)));
                in_csr_addr = addr_list[$urandom_range(0, 10)];
            end else begin
                d = sys_op(waited < 16 ? waited - 14 : (waited < 18 ? 2 : 3));
                in_csr_addr = 12'($urandom_range(0, 4095));
            end
            in_data = d;
            rnd = $urandom();
            in_pc = rnd & 32'hFFFF_FFFC;
            in_rs1_value = $urandom();
            in_rd_addr = 5'($urandom_range(0, 31));
            @(posedge clk_core); #2;
        end
        rst_core = 0; in_valid = 0; out_ready = 1;
        repeat (4) @(posedge clk_core);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
